// File: rtl/lfsr_frame_tx.sv
// lfsr_frame_tx: frames successive 20-bit LFSR words into a header/length/payload/checksum byte stream
module lfsr_frame_tx #(
  parameter int          WORDS_PER_FRAME = 8,
  parameter logic [7:0]  HEADER          = 8'hA5,
  parameter logic [15:0] FRAME_CNT_INIT  = 16'h0000
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [19:0] lfsr_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_LEN, S_PAYLOAD, S_CHECKSUM} state_t;
  state_t      state;
  logic [19:0] word;
  logic [7:0]  chk;
  logic [7:0]  word_cnt;
  logic [1:0]  byte_idx;
  logic        xfer;
  logic [7:0]  chk_next;
  logic        last_word;
  assign xfer      = tx_valid && tx_ready;
  assign chk_next  = chk ^ tx_data;
  assign last_word = word_cnt == 8'(WORDS_PER_FRAME - 1);
  // the checksum byte is the running XOR including the final payload byte
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state     <= S_IDLE;
      word      <= '0;
      chk       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= FRAME_CNT_INIT;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            state    <= S_HEADER;
            tx_data  <= HEADER;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            chk      <= '0;
            word_cnt <= '0;
            byte_idx <= '0;
          end
        S_HEADER:
          if (xfer) begin
            state   <= S_LEN;
            chk     <= chk_next;
            tx_data <= 8'(WORDS_PER_FRAME);
          end
        S_LEN:
          if (xfer) begin
            state   <= S_PAYLOAD;
            chk     <= chk_next;
            word    <= lfsr_data;
            tx_data <= {4'h0, lfsr_data[19:16]};
          end
        S_PAYLOAD:
          if (xfer) begin
            chk <= chk_next;
            if (byte_idx == 2'd0) begin
              tx_data  <= word[15:8];
              byte_idx <= 2'd1;
            end else if (byte_idx == 2'd1) begin
              tx_data  <= word[7:0];
              byte_idx <= 2'd2;
            end else if (last_word) begin
              state    <= S_CHECKSUM;
              tx_data  <= chk_next;
              byte_idx <= 2'd0;
            end else begin
              word     <= lfsr_data;
              tx_data  <= {4'h0, lfsr_data[19:16]};
              byte_idx <= 2'd0;
              word_cnt <= word_cnt + 8'd1;
            end
          end
        S_CHECKSUM:
          if (xfer) begin
            state     <= S_IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_lfsr_frame_tx.sv
// tb_lfsr_frame_tx: directed frames on three parameterisations plus a live LFSR source
module tb_lfsr_frame_tx;
  logic        clk, nreset, tx_ready;
  logic [19:0] lfsr;
  logic        start_v [3];
  logic [7:0]  td_a [3];
  logic        tv_a [3], bz_a [3], dn_a [3];
  logic [15:0] fc_a [3];
  logic [1:0]  sel;
  logic [7:0]  td;
  logic        tv, bz, dn;
  logic [15:0] fc;
  logic [15:0] exp_fc [3];
  logic [7:0]  bytes_q [$];
  logic [19:0] lv_q [$];
  int          n_checks, n_errors;

  lfsr_frame_tx #(.WORDS_PER_FRAME(1)) u1 (.clk(clk), .nreset(nreset), .start(start_v[0]), .lfsr_data(lfsr),
    .tx_data(td_a[0]), .tx_valid(tv_a[0]), .tx_ready(tx_ready), .busy(bz_a[0]), .done(dn_a[0]), .frame_cnt(fc_a[0]));
  lfsr_frame_tx #(.WORDS_PER_FRAME(2), .FRAME_CNT_INIT(16'hFFFF)) u2 (.clk(clk), .nreset(nreset), .start(start_v[1]),
    .lfsr_data(lfsr), .tx_data(td_a[1]), .tx_valid(tv_a[1]), .tx_ready(tx_ready), .busy(bz_a[1]), .done(dn_a[1]),
    .frame_cnt(fc_a[1]));
  lfsr_frame_tx u8 (.clk(clk), .nreset(nreset), .start(start_v[2]), .lfsr_data(lfsr),
    .tx_data(td_a[2]), .tx_valid(tv_a[2]), .tx_ready(tx_ready), .busy(bz_a[2]), .done(dn_a[2]), .frame_cnt(fc_a[2]));

  assign td = td_a[sel];
  assign tv = tv_a[sel];
  assign bz = bz_a[sel];
  assign dn = dn_a[sel];
  assign fc = fc_a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // drives one frame on instance s and checks it against a byte-level model of the framing
  task automatic run_frame(input int s, input int wpf, input bit live, input int stall_at, input bit restart);
    int total, c, stalls, w, b;
    bit pend, pstall;
    logic [7:0] ptd, chk, e;
    logic [19:0] cap [256];
    total = 3 * wpf + 3;
    stalls = 0; pend = 0; pstall = 0; ptd = '0; w = 0; b = 0;
    sel = 2'(s);
    bytes_q.delete();
    lv_q.delete();
    start_v[s] = 1'b1;
    for (c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("hdr_valid", 32'(tv), 32'd1);
        check("hdr_data", 32'(td), 32'hA5);
        check("busy", 32'(bz), 32'd1);
        check("done_pulse", 32'(dn), 32'd0);
      end
      if (pstall) begin
        check("stall_data", 32'(td), 32'(ptd));
        check("stall_valid", 32'(tv), 32'd1);
      end
      if (pend) begin
        check("done", 32'(dn), 32'd1);
        check("idle_valid", 32'(tv), 32'd0);
        check("idle_busy", 32'(bz), 32'd0);
        exp_fc[s] = exp_fc[s] + 16'd1;
        check("frame_cnt", 32'(fc), 32'(exp_fc[s]));
        if (!live) check("cycles", 32'(c), 32'(total + 1 + (stall_at >= 0 ? 3 : 0)));
        start_v[s] = restart;
        break;
      end
      start_v[s] = (c == 3 || c == 6);
      if (stall_at == bytes_q.size() && stalls < 3) begin
        tx_ready = 1'b0;
        stalls++;
      end else tx_ready = live ? 1'($urandom_range(0, 1)) : 1'b1;
      if (live) lfsr = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
      if (tv && tx_ready) begin
        bytes_q.push_back(td);
        lv_q.push_back(lfsr);
        if (bytes_q.size() == total) pend = 1;
      end
      pstall = tv && !tx_ready;
      ptd = td;
    end
    check("terminated", 32'(c <= 3000), 32'd1);
    check("nbytes", 32'(bytes_q.size()), 32'(total));
    chk = '0;
    foreach (bytes_q[p]) begin
      if (p == 0) e = 8'hA5;
      else if (p == 1) e = 8'(wpf);
      else if (p == total - 1) e = chk;
      else begin
        w = (p - 2) / 3;
        b = (p - 2) % 3;
        e = b == 0 ? {4'h0, cap[w][19:16]} : b == 1 ? cap[w][15:8] : cap[w][7:0];
      end
      if (p == 1) cap[0] = lv_q[p];
      if (p > 1 && p < total - 1 && b == 2 && w < wpf - 1) cap[w + 1] = lv_q[p];
      check("model_byte", 32'(bytes_q[p]), 32'(e));
      chk ^= e;
    end
    if (!restart) begin
      tx_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("no_extra", 32'(tv), 32'd0);
      check("done_once", 32'(dn), 32'd0);
    end
  endtask

  logic [7:0] exp_min [6] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h01, 8'hA4};
  logic [7:0] exp_two [9] = '{8'hA5, 8'h02, 8'h0F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hA7};

  initial begin
    n_checks = 0; n_errors = 0;
    nreset = 1'b0; tx_ready = 1'b0; lfsr = '0; sel = 2'd0;
    start_v = '{1'b0, 1'b0, 1'b0};
    exp_fc = '{16'h0000, 16'hFFFF, 16'h0000};
    repeat (2) @(negedge clk);
    check("rst_data", 32'(td), 32'h0);
    check("rst_valid", 32'(tv), 32'd0);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_done", 32'(dn), 32'd0);
    check("rst_cnt", 32'(fc), 32'h0);
    nreset = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("pre_rst_valid", 32'(tv), 32'd1);
    #2 nreset = 1'b0;
    #1;
    check("async_valid", 32'(tv), 32'd0);
    check("async_busy", 32'(bz), 32'd0);
    check("async_done", 32'(dn), 32'd0);
    check("async_data", 32'(td), 32'h0);
    check("async_cnt", 32'(fc), 32'h0);
    #1 nreset = 1'b1;
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(tv), 32'd0);
    check("post_rst_cnt", 32'(fc), 32'h0);
    lfsr = 20'h00101;
    run_frame(0, 1, 1'b0, -1, 1'b0);
    foreach (exp_min[i]) check("min_byte", 32'(bytes_q[i]), 32'(exp_min[i]));
    run_frame(0, 1, 1'b0, -1, 1'b1);
    run_frame(0, 1, 1'b0, -1, 1'b0);
    check("cnt_three", 32'(fc), 32'd3);
    lfsr = 20'hFFFFF;
    run_frame(1, 2, 1'b0, 3, 1'b0);
    foreach (exp_two[i]) check("two_byte", 32'(bytes_q[i]), 32'(exp_two[i]));
    check("wrap", 32'(fc), 32'h0);
    lfsr = 20'h5A3C1;
    run_frame(2, 8, 1'b1, -1, 1'b1);
    run_frame(2, 8, 1'b1, -1, 1'b0);
    check("live_cnt", 32'(fc), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lfsr_frame_tx.md
# lfsr_frame_tx

Framing stage directly downstream of the 20-bit free-running LFSR pattern generator in the FPGA interface path. On a start request it samples successive LFSR words, splits each into three bytes, and wraps them in a header/length/checksum frame. The frame leaves on an 8-bit valid/ready byte stream towards the host link. It is the only consumer of the LFSR output and adds no buffering beyond one word register and one output byte register.

## Interface
- WORDS_PER_FRAME, 8: LFSR words per frame; legal range 1..255; sent as the LEN byte.
- HEADER, 8'hA5: first byte of every frame.

- clk  in  1  system clock, rising edge.
- nreset  in  1  asynchronous, active-low reset. Clears all state immediately on assertion.
- start  in  1  frame request, sampled only in IDLE.
- lfsr_data  in  20  LFSR word; may change every cycle.
- tx_data  out  8  output byte; registered.
- tx_valid  out  1  tx_data is valid; registered.
- tx_ready  in  1  sink accepts the byte; transfer = tx_valid && tx_ready.
- busy  out  1  high from the cycle after start is accepted until the last byte transfers.
- done  out  1  one-cycle pulse in the cycle after the checksum byte transfers.
- frame_cnt  out  16  completed frames; wraps 16'hFFFF -> 0.

## Operation
- States: IDLE, HEADER, LEN, PAYLOAD, CHECKSUM.
  - IDLE + start -> HEADER.
  - HEADER transfer -> LEN.
  - LEN transfer -> PAYLOAD.
  - Transfer of the last payload byte (word WORDS_PER_FRAME-1, byte 2) -> CHECKSUM.
  - CHECKSUM transfer -> IDLE.
- Frame byte order: HEADER, LEN, then per word w: {4'b0, w[19:16]}, w[15:8], w[7:0], then CHK. Total 3*WORDS_PER_FRAME+3 bytes.
- Word capture: lfsr_data is latched into the word register on the clock edge that loads that word's byte 0 into tx_data. That edge is the LEN transfer for word 0, or the previous word's byte-2 transfer for every later word. lfsr_data is not re-sampled during stalls.
- Counters:
  - byte index 0..2 wraps to 0 after byte 2 and increments the word counter.
  - The 8-bit word counter resets to 0 on entry to HEADER.
- CHK = XOR of every byte from HEADER through the last payload byte. The accumulator clears on entry to HEADER and updates on each transfer.
- start while busy is ignored (no queuing).
- frame_cnt increments on the same edge that asserts done.

## Timing
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, done=0, frame_cnt=0, state=IDLE, word register=0, checksum=0.
- start high at edge N (IDLE) -> tx_valid=1, tx_data=HEADER, busy=1 after edge N.
- Throughput: with tx_ready held high, one byte per cycle with no bubbles, including across word boundaries and into CHK.
- Handshake:
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - The next byte appears the cycle after a transfer.
  - tx_valid never drops mid-frame.
- After the CHK transfer edge: tx_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE.
- start high during the done cycle is accepted; HEADER appears on the following cycle.
- nreset asserted mid-frame: the frame aborts and outputs return to reset values without waiting for clk. frame_cnt does not increment. No partial frame resumes after release.
- Behaviour for WORDS_PER_FRAME outside 1..255 is not supported.

## Test plan
- Reset: pulse nreset low between clock edges mid-HEADER -> tx_valid, busy and done are 0 immediately, frame_cnt=0, and no bytes appear after release without a new start.
- Minimal frame: WORDS_PER_FRAME=1, lfsr_data held at 20'h00101, tx_ready=1, start for one cycle -> bytes A5 01 00 01 01 A4 on 6 consecutive cycles; done one cycle later; frame_cnt=1.
- Two words with backpressure: WORDS_PER_FRAME=2, lfsr_data=20'hFFFFF, tx_ready low for 3 cycles on the second payload byte -> bytes A5 02 0F FF FF 0F FF FF A7; tx_data stable during the stall.
- Live LFSR source: connected to the LFSR generator, default parameters, random tx_ready -> 27 bytes per frame. Each word equals the model LFSR value at its capture edge, and CHK matches the model.
- Start handling: start pulses during a frame are ignored (exactly one frame produced). start asserted in the done cycle -> HEADER on the next cycle; frame_cnt increments by 1 per frame.
- Wrap: force frame_cnt to 16'hFFFF via back-to-back frames or a preload test hook -> the next done sets frame_cnt=0.
